gpp16_io_port: RTL and testbench
================================

# gpp16_io_port

Memory-mapped I/O port for the GPP16 processor. It sits directly downstream of the core's bus outputs (ADDR_BUS, DO, wrmem, ioe) and decodes I/O accesses into a four-register window. The window holds a transmit FIFO drained over a valid/ready stream, a single-entry receive holding register filled over a valid/ready stream, status, and control. Read data and a select flag go back to the system DI multiplexer. An interrupt line is raised on receive-data-available or transmit-empty.

## Interface
- DEPTH, 8: TX FIFO entries; power of two, 2..16.
- IO_BASE, 16'hFF00: window base; bits [1:0] ignored.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr_bus  in  16  core ADDR_BUS.
- cpu_do  in  16  core DO (write data).
- wrmem  in  1  core write strobe; 1 = write, 0 = read.
- ioe  in  1  core I/O-enable strobe.
- io_sel  out  1  combinational: ioe & (addr_bus[15:2] == IO_BASE[15:2]); steers the DI mux.
- io_rdata  out  16  registered read data.
- tx_data  out  16  FIFO head word.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts head.
- rx_data  in  16  inbound word.
- rx_valid  in  1  inbound word valid.
- rx_ready  out  1  = ~rx_full.
- irq  out  1  registered interrupt request.

## Operation
- Register map (offset = addr_bus[1:0]):
  - 0 TXDATA: a write pushes cpu_do; a read returns 0.
  - 1 RXDATA: a read returns rx_hold and clears rx_full; a write is ignored.
  - 2 STATUS (read): [0] tx_full, [1] tx_empty, [2] rx_full, [3] tx_drop (sticky), [8:4] tx_count, other bits 0. Writing 1 to bit 3 clears tx_drop; all other bits are ignored.
  - 3 CTRL (r/w): [0] rx_irq_en, [1] txe_irq_en; other bits read as 0.
- Access edge: acc = io_sel, with acc_q as its registered copy. Side effects and read capture occur only on the first cycle of an access (acc & ~acc_q). A strobe held for N cycles counts as one access.
- TX FIFO:
  - Circular buffer with rd/wr pointers and a count of log2(DEPTH)+1 bits.
  - A push is accepted only if count < DEPTH, evaluated before any same-cycle pop. A rejected push sets tx_drop; contents are unchanged.
  - A pop occurs on tx_valid & tx_ready. Push and pop in the same cycle (not full) leaves count unchanged. Pointers wrap modulo DEPTH.
  - tx_data = mem[rd_ptr]; it must stay stable while tx_valid & ~tx_ready.
- RX: on rx_valid & rx_ready, rx_hold <= rx_data and rx_full <= 1. Accept and RXDATA-read clear cannot coincide, because accept requires ~rx_full. Reading RXDATA while empty returns stale rx_hold and has no effect.
- irq <= (rx_full & rx_irq_en) | (tx_empty & txe_irq_en), computed from the current-cycle state.

## Timing
- Reset values: io_rdata = 0, tx_valid = 0, rx_ready = 1, irq = 0, tx_drop = 0, CTRL = 0, FIFO empty, rx_hold = 0, acc_q = 0. Reset may assert mid-access or mid-stream; all state clears immediately.
- Read latency is 1 cycle. io_rdata is loaded at the first-cycle edge and holds until the next read's first cycle. STATUS captures its value before same-edge side effects.
- Write-to-tx_valid latency: 1 cycle after the first-cycle edge.
- Read-to-rx_ready: rx_ready rises 1 cycle after the RXDATA read edge.
- irq lags its sources by 1 cycle.
- Back-to-back accesses with no idle cycle between them (acc held) are a single access. The core must deassert ioe between accesses.

## Test plan
- Reset, then write 16'h0041 to FF00 -> next cycle tx_valid = 1, tx_data = 0041, STATUS reads 16'h0010 (count 1).
- With tx_ready = 0, push 9 words with DEPTH = 8 -> STATUS = 16'h0089 (count 8, tx_drop, full). Then raise tx_ready -> 8 words drain in order, 1 per cycle, then tx_valid = 0. Writing 16'h0008 to FF02 clears tx_drop.
- rx_data = 16'hBEEF with rx_valid held -> rx_ready falls 1 cycle after the accept. Read FF01 -> io_rdata = BEEF and rx_ready = 1 the next cycle. A second word is accepted only after that.
- CTRL = 3 with FIFO empty -> irq = 1. Push a word with tx_ready = 0 -> irq stays 1 only while rx_full; with rx empty it drops 1 cycle after tx_empty falls.
- Hold ioe on a TXDATA write for 5 cycles -> exactly one push (count 1).
- Assert rst_n low mid-drain and mid-read -> all outputs are at reset values in the same cycle; the FIFO is empty after release.

Source files
------------

// File: rtl/gpp16_io_port.sv
// GPP16 memory-mapped I/O port: four-register window with a TX FIFO stream,
// a single-entry RX holding register, status/control and an interrupt line.
module gpp16_io_port #(
    parameter int          DEPTH   = 8,
    parameter logic [15:0] IO_BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr_bus,
    input  logic [15:0] cpu_do,
    input  logic        wrmem,
    input  logic        ioe,
    output logic        io_sel,
    output logic [15:0] io_rdata,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_RXDATA = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    logic          acc_q;
    logic          first_cycle;
    logic          wr_stb;
    logic          rd_stb;
    logic [1:0]    offset;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          tx_full;
    logic          tx_empty;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          tx_drop;

    logic [15:0]   rx_hold;
    logic          rx_full;
    logic          rx_accept;

    logic          rx_irq_en;
    logic          txe_irq_en;

    logic [15:0]   status;
    logic [15:0]   rdata_next;

    // An access is a contiguous run of io_sel; only its first cycle has side effects.
    assign io_sel      = ioe & (addr_bus[15:2] == IO_BASE[15:2]);
    assign first_cycle = io_sel & ~acc_q;
    assign wr_stb      = first_cycle & wrmem;
    assign rd_stb      = first_cycle & ~wrmem;
    assign offset      = addr_bus[1:0];

    assign tx_full   = (count == CW'(DEPTH));
    assign tx_empty  = (count == '0);
    assign tx_valid  = ~tx_empty;
    assign tx_data   = mem[rd_ptr];
    assign push_req  = wr_stb & (offset == OFF_TXDATA);
    assign push_ok   = push_req & ~tx_full;
    assign pop       = tx_valid & tx_ready;

    assign rx_ready  = ~rx_full;
    assign rx_accept = rx_valid & ~rx_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= io_sel;
        end
    end

    // Fullness is judged on the pre-pop count, so a full FIFO rejects a push even while draining.
    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= cpu_do;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_drop <= 1'b0;
        end else if (push_req && !push_ok) begin
            tx_drop <= 1'b1;
        end else if (wr_stb && offset == OFF_STATUS && cpu_do[3]) begin
            tx_drop <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_irq_en  <= 1'b0;
            txe_irq_en <= 1'b0;
        end else if (wr_stb && offset == OFF_CTRL) begin
            rx_irq_en  <= cpu_do[0];
            txe_irq_en <= cpu_do[1];
        end
    end

    // Accept only happens while empty, so it never collides with an RXDATA read clearing a full register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hold <= '0;
            rx_full <= 1'b0;
        end else if (rx_accept) begin
            rx_hold <= rx_data;
            rx_full <= 1'b1;
        end else if (rd_stb && offset == OFF_RXDATA) begin
            rx_full <= 1'b0;
        end
    end

    always_comb begin
        status      = '0;
        status[0]   = tx_full;
        status[1]   = tx_empty;
        status[2]   = rx_full;
        status[3]   = tx_drop;
        status[8:4] = 5'(count);
    end

    always_comb begin
        rdata_next = '0;
        case (offset)
            OFF_TXDATA: rdata_next = '0;
            OFF_RXDATA: rdata_next = rx_hold;
            OFF_STATUS: rdata_next = status;
            OFF_CTRL:   rdata_next = {14'd0, txe_irq_en, rx_irq_en};
            default:    rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_rdata <= '0;
        end else if (rd_stb) begin
            io_rdata <= rdata_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= (rx_full & rx_irq_en) | (tx_empty & txe_irq_en);
        end
    end

endmodule

// File: tb/tb_gpp16_io_port.sv
// Bench for gpp16_io_port: directed scenarios with literal expectations plus a
// randomized phase, all checked each cycle against a queue-based model.
module tb_gpp16_io_port;

    localparam int          DEPTH   = 8;
    localparam logic [15:0] IO_BASE = 16'hFF00;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr_bus;
    logic [15:0] cpu_do;
    logic        wrmem;
    logic        ioe;
    logic        io_sel;
    logic [15:0] io_rdata;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        irq;

    gpp16_io_port #(.DEPTH(DEPTH), .IO_BASE(IO_BASE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr_bus (addr_bus),
        .cpu_do   (cpu_do),
        .wrmem    (wrmem),
        .ioe      (ioe),
        .io_sel   (io_sel),
        .io_rdata (io_rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: FIFO as a queue, everything else as plain flags.
    logic [15:0] mq[$];
    bit          m_in_access = 1'b0;
    bit          m_rx_full   = 1'b0;
    bit          m_drop      = 1'b0;
    bit          m_irq       = 1'b0;
    logic [15:0] m_hold      = '0;
    logic [15:0] m_rdata     = '0;
    logic [1:0]  m_ctrl      = '0;

    function automatic bit inWindow(input logic [15:0] a, input logic e);
        return e && ((a & 16'hFFFC) == (IO_BASE & 16'hFFFC));
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int  n;
        int  st;
        bit  sel;
        bit  first;
        bit  push;
        bit  irq_next;
        bit  rx_acc;
        if (!rst_n) begin
            mq.delete();
            m_in_access = 1'b0;
            m_rx_full   = 1'b0;
            m_drop      = 1'b0;
            m_irq       = 1'b0;
            m_hold      = '0;
            m_rdata     = '0;
            m_ctrl      = '0;
        end else begin
            n        = mq.size();
            sel      = inWindow(addr_bus, ioe);
            first    = sel && !m_in_access;
            push     = 1'b0;
            irq_next = (m_rx_full && m_ctrl[0]) || (n == 0 && m_ctrl[1]);
            rx_acc   = rx_valid && !m_rx_full;
            st = n * 16 + ((n == DEPTH) ? 1 : 0) + ((n == 0) ? 2 : 0)
               + (m_rx_full ? 4 : 0) + (m_drop ? 8 : 0);
            if (first && wrmem) begin
                case (addr_bus[1:0])
                    2'd0: if (n < DEPTH) push = 1'b1; else m_drop = 1'b1;
                    2'd2: if (cpu_do[3]) m_drop = 1'b0;
                    2'd3: m_ctrl = cpu_do[1:0];
                    default: ;
                endcase
            end
            if (first && !wrmem) begin
                case (addr_bus[1:0])
                    2'd0: m_rdata = 16'h0000;
                    2'd1: begin m_rdata = m_hold; m_rx_full = 1'b0; end
                    2'd2: m_rdata = 16'(st);
                    default: m_rdata = {14'd0, m_ctrl};
                endcase
            end
            if (rx_acc) begin
                m_hold    = rx_data;
                m_rx_full = 1'b1;
            end
            if (n > 0 && tx_ready) void'(mq.pop_front());
            if (push) mq.push_back(cpu_do);
            m_irq       = irq_next;
            m_in_access = sel;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("io_sel", 16'(io_sel), 16'(inWindow(addr_bus, ioe)));
            checkOutput("io_rdata", io_rdata, m_rdata);
            checkOutput("tx_valid", 16'(tx_valid), 16'(mq.size() != 0));
            if (mq.size() != 0) checkOutput("tx_data", tx_data, mq[0]);
            checkOutput("rx_ready", 16'(rx_ready), 16'(!m_rx_full));
            checkOutput("irq", 16'(irq), 16'(m_irq));
        end
    end

    // One bus access: strobe held for 'hold' edges, then released.
    task automatic applyStimulus(input bit wr, input logic [15:0] addr, input logic [15:0] data, input int hold);
        @(posedge clk); #1;
        ioe      = 1'b1;
        wrmem    = wr;
        addr_bus = addr;
        cpu_do   = data;
        repeat (hold) @(posedge clk);
        #1;
        ioe   = 1'b0;
        wrmem = 1'b0;
    endtask

    task automatic ioRead(input logic [15:0] addr, output logic [15:0] data);
        applyStimulus(1'b0, addr, 16'h0000, 1);
        @(negedge clk);
        data = io_rdata;
    endtask

    task automatic drainFifo();
        @(posedge clk); #1;
        tx_ready = 1'b1;
        repeat (DEPTH + 1) @(posedge clk);
        #1;
        tx_ready = 1'b0;
    endtask

    initial begin : stim
        logic [15:0] v;
        int          hold_left;
        rst_n = 1'b0; ioe = 1'b0; wrmem = 1'b0; addr_bus = '0; cpu_do = '0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset io_rdata", io_rdata, 16'h0000);
        checkOutput("reset tx_valid", 16'(tx_valid), 16'h0000);
        checkOutput("reset rx_ready", 16'(rx_ready), 16'h0001);
        checkOutput("reset irq", 16'(irq), 16'h0000);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        $display("[TB] single push");
        applyStimulus(1'b1, 16'hFF00, 16'h0041, 1);
        @(negedge clk);
        checkOutput("push tx_valid", 16'(tx_valid), 16'h0001);
        checkOutput("push tx_data", tx_data, 16'h0041);
        ioRead(16'hFF02, v);
        checkOutput("status count1", v, 16'h0010);
        drainFifo();

        $display("[TB] overflow and drain");
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 16'hFF00, 16'h1000 + 16'(i), 1);
        ioRead(16'hFF02, v);
        checkOutput("status full+drop", v, 16'h0089);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            checkOutput("drain valid", 16'(tx_valid), 16'h0001);
            checkOutput("drain order", tx_data, 16'h1000 + 16'(i));
        end
        @(negedge clk);
        checkOutput("drained valid", 16'(tx_valid), 16'h0000);
        tx_ready = 1'b0;
        applyStimulus(1'b1, 16'hFF02, 16'h0008, 1);
        ioRead(16'hFF02, v);
        checkOutput("drop cleared", v, 16'h0002);

        $display("[TB] receive path");
        @(posedge clk); #1;
        rx_data  = 16'hBEEF;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_data = 16'h1234;
        @(negedge clk);
        checkOutput("rx_ready after accept", 16'(rx_ready), 16'h0000);
        ioRead(16'hFF01, v);
        checkOutput("rxdata read", v, 16'hBEEF);
        checkOutput("rx_ready after read", 16'(rx_ready), 16'h0001);
        @(negedge clk);
        checkOutput("second accept", 16'(rx_ready), 16'h0000);
        ioRead(16'hFF01, v);
        rx_valid = 1'b0;
        checkOutput("second rxdata", v, 16'h1234);

        $display("[TB] interrupts");
        applyStimulus(1'b1, 16'hFF03, 16'h0003, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("irq tx empty", 16'(irq), 16'h0001);
        ioRead(16'hFF03, v);
        checkOutput("ctrl readback", v, 16'h0003);
        applyStimulus(1'b1, 16'hFF00, 16'hABCD, 1);
        @(negedge clk);
        checkOutput("irq lag", 16'(irq), 16'h0001);
        @(negedge clk);
        checkOutput("irq drops", 16'(irq), 16'h0000);
        drainFifo();

        $display("[TB] held strobe");
        applyStimulus(1'b1, 16'hFF00, 16'h5555, 5);
        ioRead(16'hFF02, v);
        checkOutput("held strobe one push", v, 16'h0010);
        drainFifo();

        $display("[TB] reset mid-drain and mid-read");
        @(posedge clk); #1;
        rx_data  = 16'h7777;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'hFF00, 16'h2000 + 16'(i), 1);
        ioRead(16'hFF02, v);
        checkOutput("status before reset", v, 16'h0044);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        ioe      = 1'b1;
        wrmem    = 1'b0;
        addr_bus = 16'hFF02;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async io_rdata", io_rdata, 16'h0000);
        checkOutput("async tx_valid", 16'(tx_valid), 16'h0000);
        checkOutput("async rx_ready", 16'(rx_ready), 16'h0001);
        checkOutput("async irq", 16'(irq), 16'h0000);
        ioe      = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("empty after reset", 16'(tx_valid), 16'h0000);
        ioRead(16'hFF02, v);
        checkOutput("status after reset", v, 16'h0002);

        $display("[TB] randomized traffic");
        hold_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            tx_ready = ((cyc / 200) % 2 == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 16'($urandom);
            if (hold_left > 0) begin
                hold_left--;
            end else if (ioe) begin
                ioe = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                ioe      = 1'b1;
                wrmem    = ($urandom_range(0, 3) != 0);
                addr_bus = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                       : (IO_BASE | 16'($urandom_range(0, 3)));
                cpu_do   = 16'($urandom);
                hold_left = $urandom_range(0, 3);
            end
        end
        @(posedge clk); #1;
        ioe      = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (DEPTH + 2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
